// File: rtl/cache_line_writeback_if.sv
// Request, data-RAM read port and AXI write channels of the cache line writeback engine.
// The master modport is the writeback engine's view; slave is the controller/RAM/bus side.
interface cache_line_writeback_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned INDEX_WIDTH    = 8,
    parameter int unsigned TAG_WIDTH      = 20,
    parameter int unsigned OFF_WIDTH      = $clog2(WORDS_PER_LINE)
);
    logic                             req_valid;
    logic                             req_ready;
    logic [TAG_WIDTH-1:0]             req_tag;
    logic [INDEX_WIDTH-1:0]           req_index;
    logic                             ram_enb;
    logic [INDEX_WIDTH+OFF_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0]            ram_doutb;
    logic                             line_taken;
    logic                             awvalid;
    logic                             awready;
    logic [31:0]                      awaddr;
    logic [7:0]                       awlen;
    logic [2:0]                       awsize;
    logic [1:0]                       awburst;
    logic                             wvalid;
    logic                             wready;
    logic [DATA_WIDTH-1:0]            wdata;
    logic [DATA_WIDTH/8-1:0]          wstrb;
    logic                             wlast;
    logic                             bvalid;
    logic                             bready;
    logic [1:0]                       bresp;
    logic                             wb_done;
    logic                             wb_err;

    modport master (
        input  req_valid, req_tag, req_index, ram_doutb, awready, wready, bvalid, bresp,
        output req_ready, ram_enb, ram_addrb, line_taken, awvalid, awaddr, awlen, awsize,
               awburst, wvalid, wdata, wstrb, wlast, bready, wb_done, wb_err
    );

    modport slave (
        output req_valid, req_tag, req_index, ram_doutb, awready, wready, bvalid, bresp,
        input  req_ready, ram_enb, ram_addrb, line_taken, awvalid, awaddr, awlen, awsize,
               awburst, wvalid, wdata, wstrb, wlast, bready, wb_done, wb_err
    );
endinterface

// File: rtl/cache_line_writeback.sv
// Buffers one dirty cache line from the data RAM, then drains it as a single AXI INCR write burst.
// The RAM is released (line_taken) as soon as the last word is buffered.
module cache_line_writeback #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned INDEX_WIDTH    = 8,
    parameter int unsigned TAG_WIDTH      = 20
) (
    input  logic                    clk,
    input  logic                    resetn,
    cache_line_writeback_if.master  bus
);
    localparam int unsigned OFF_WIDTH = $clog2(WORDS_PER_LINE);
    localparam logic [OFF_WIDTH:0]   RD_END  = (OFF_WIDTH+1)'(WORDS_PER_LINE);
    localparam logic [OFF_WIDTH-1:0] WR_LAST = OFF_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, READ, AW, W, B} state_t;

    state_t                 state, next_state;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [OFF_WIDTH:0]     rd_cnt;
    logic [OFF_WIDTH-1:0]   wr_cnt;
    logic [OFF_WIDTH-1:0]   fill_idx;
    logic [DATA_WIDTH-1:0]  line_buf [WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (bus.req_valid) next_state = READ;
            READ: if (rd_cnt == RD_END) next_state = AW;
            AW:   if (bus.awready) next_state = W;
            W:    if (bus.wready && wr_cnt == WR_LAST) next_state = B;
            B:    if (bus.bvalid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // RAM data lags the address by one cycle, so word rd_cnt-1 lands while rd_cnt is issued.
    always_comb fill_idx = OFF_WIDTH'(rd_cnt - 1'b1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) rd_cnt <= '0;
                READ: if (rd_cnt != RD_END) rd_cnt <= rd_cnt + 1'b1;
                AW:   wr_cnt <= '0;
                W:    if (bus.wready) wr_cnt <= wr_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            tag_q   <= bus.req_tag;
            index_q <= bus.req_index;
        end
        if (state == READ && rd_cnt != '0) line_buf[fill_idx] <= bus.ram_doutb;
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.ram_enb    = (state == READ) && (rd_cnt < RD_END);
        bus.ram_addrb  = {index_q, rd_cnt[OFF_WIDTH-1:0]};
        bus.line_taken = (state == READ) && (rd_cnt == RD_END);
        bus.awvalid    = (state == AW);
        bus.awaddr     = {tag_q, index_q, {OFF_WIDTH{1'b0}}, 2'b00};
        bus.awlen      = 8'(WORDS_PER_LINE - 1);
        bus.awsize     = 3'b010;
        bus.awburst    = 2'b01;
        bus.wvalid     = (state == W);
        bus.wdata      = line_buf[wr_cnt];
        bus.wstrb      = '1;
        bus.wlast      = (state == W) && (wr_cnt == WR_LAST);
        bus.bready     = (state == B);
        bus.wb_done    = (state == B) && bus.bvalid;
        bus.wb_err     = (state == B) && bus.bvalid && (bus.bresp != 2'b00);
    end
endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed bench for cache_line_writeback: a transaction-level model predicts every output each cycle,
// and a few literal expectations pin the model for the basic, back-to-back and error cases.
module tb_cache_line_writeback;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_line_writeback_if #(.DATA_WIDTH(32), .WORDS_PER_LINE(4), .INDEX_WIDTH(8), .TAG_WIDTH(20)) ifc ();

    cache_line_writeback #(.DATA_WIDTH(32), .WORDS_PER_LINE(4), .INDEX_WIDTH(8), .TAG_WIDTH(20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Data RAM with one-cycle read latency.
    logic [31:0] ram [1024];
    always @(posedge clk) if (ifc.ram_enb) ifc.ram_doutb <= ram[ifc.ram_addrb];

    // Transaction model: one outstanding writeback, tracked by cycles since accept and beats sent.
    int          cyc = 0;
    bit          started = 1'b0;
    bit          active = 1'b0;
    bit          aw_done = 1'b0;
    int          beat = 0;
    int          acc_cyc = 0;
    int          last_done_cyc = 0;
    int          gap = 0;
    int          n_accept = 0, n_done = 0, n_err = 0, n_beats = 0, n_taken = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_line [4];
    logic [31:0] seen_awaddr = '0;
    logic [31:0] seen [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) begin
            active  <= 1'b0;
            aw_done <= 1'b0;
            beat    <= 0;
        end else begin
            if (ifc.req_valid && ifc.req_ready) begin
                active   <= 1'b1;
                aw_done  <= 1'b0;
                beat     <= 0;
                acc_cyc  <= cyc;
                gap      <= cyc - last_done_cyc;
                exp_addr <= {ifc.req_tag, ifc.req_index, 4'h0};
                for (int i = 0; i < 4; i++) exp_line[i] <= ram[{ifc.req_index, 2'(i)}];
                n_accept <= n_accept + 1;
            end
            if (ifc.awvalid && ifc.awready) begin
                aw_done     <= 1'b1;
                seen_awaddr <= ifc.awaddr;
            end
            if (ifc.wvalid && ifc.wready) begin
                beat    <= beat + 1;
                n_beats <= n_beats + 1;
                seen.push_back(ifc.wdata);
            end
            if (ifc.line_taken) n_taken <= n_taken + 1;
            if (ifc.wb_done) begin
                active        <= 1'b0;
                n_done        <= n_done + 1;
                last_done_cyc <= cyc;
                if (ifc.wb_err) n_err <= n_err + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        int d;
        if (started && resetn) begin
            d = cyc - acc_cyc;
            chk("req_ready", ifc.req_ready, !active);
            chk("ram_enb", ifc.ram_enb, active && d >= 1 && d <= 4);
            if (active && d >= 1 && d <= 4) chk("ram_addrb", ifc.ram_addrb, {exp_addr[11:4], 2'(d - 1)});
            chk("line_taken", ifc.line_taken, active && d == 5);
            chk("awvalid", ifc.awvalid, active && d >= 6 && !aw_done);
            if (ifc.awvalid) begin
                chk("awaddr", ifc.awaddr, exp_addr);
                chk("awlen", ifc.awlen, 8'd3);
                chk("awsize", ifc.awsize, 3'b010);
                chk("awburst", ifc.awburst, 2'b01);
            end
            chk("wvalid", ifc.wvalid, active && aw_done && beat < 4);
            if (ifc.wvalid && beat < 4) begin
                chk("wdata", ifc.wdata, exp_line[beat]);
                chk("wlast", ifc.wlast, beat == 3);
                chk("wstrb", ifc.wstrb, 4'hF);
            end
            chk("bready", ifc.bready, active && beat == 4);
            chk("wb_done", ifc.wb_done, active && beat == 4 && ifc.bvalid);
            chk("wb_err", ifc.wb_err, active && beat == 4 && ifc.bvalid && ifc.bresp != 2'b00);
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"}, ifc.req_ready, 1'b1);
        chk({tag, "_ram_enb"}, ifc.ram_enb, 1'b0);
        chk({tag, "_line_taken"}, ifc.line_taken, 1'b0);
        chk({tag, "_awvalid"}, ifc.awvalid, 1'b0);
        chk({tag, "_wvalid"}, ifc.wvalid, 1'b0);
        chk({tag, "_bready"}, ifc.bready, 1'b0);
        chk({tag, "_wb_done"}, ifc.wb_done, 1'b0);
        chk({tag, "_wb_err"}, ifc.wb_err, 1'b0);
    endtask

    task automatic issue(input logic [19:0] tag, input logic [7:0] idx);
        int a0;
        a0 = n_accept;
        ifc.req_tag   = tag;
        ifc.req_index = idx;
        ifc.req_valid = 1'b1;
        for (int i = 0; i < 50 && n_accept == a0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", n_accept != a0, 1'b1);
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && n_done < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_timeout", n_done >= target, 1'b1);
    endtask

    task automatic wait_wvalid();
        for (int i = 0; i < 50 && !ifc.wvalid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wvalid_timeout", ifc.wvalid, 1'b1);
    endtask

    initial begin
        int base_done, base_err, base_beats, base_taken, a0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'hD000_0000 | i;
        for (int k = 0; k < 4; k++) begin
            ram[{8'h3C, 2'(k)}] = 32'hA0 + k;
            ram[{8'h3D, 2'(k)}] = 32'hB0 + k;
        end
        ifc.req_valid = 1'b0;
        ifc.req_tag   = '0;
        ifc.req_index = '0;
        ifc.awready   = 1'b1;
        ifc.wready    = 1'b1;
        ifc.bvalid    = 1'b1;
        ifc.bresp     = 2'b00;

        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        started = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // T1 basic
        base_done = n_done; base_err = n_err;
        seen.delete();
        issue(20'h12345, 8'h3C);
        wait_done(base_done + 1);
        chk("t1_awaddr", seen_awaddr, 32'h123453C0);
        chk("t1_beats", seen.size(), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++) chk("t1_wdata", seen[k], 32'hA0 + k);
        chk("t1_done_cnt", n_done - base_done, 1);
        chk("t1_err_cnt", n_err - base_err, 0);

        // T2 W backpressure
        base_done = n_done; base_beats = n_beats;
        ifc.wready = 1'b0;
        issue(20'h0AAAA, 8'h3D);
        for (int b = 0; b < 4; b++) begin
            wait_wvalid();
            repeat (3) @(posedge clk);
            #1 ifc.wready = 1'b1;
            @(posedge clk);
            #1 ifc.wready = 1'b0;
        end
        ifc.wready = 1'b1;
        wait_done(base_done + 1);
        chk("t2_beats", n_beats - base_beats, 4);

        // T3 AW stall
        base_done = n_done; base_taken = n_taken;
        ifc.awready = 1'b0;
        issue(20'h00777, 8'h3C);
        for (int i = 0; i < 50 && !ifc.awvalid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t3_awvalid_seen", ifc.awvalid, 1'b1);
        repeat (5) @(posedge clk);
        #1 ifc.awready = 1'b1;
        wait_done(base_done + 1);
        chk("t3_taken_cnt", n_taken - base_taken, 1);

        // T4 back-to-back: second request held from the first accept
        base_done = n_done;
        seen.delete();
        issue(20'hABCDE, 8'h3C);
        a0 = n_accept;
        ifc.req_tag   = 20'h0F0F0;
        ifc.req_index = 8'h3D;
        ifc.req_valid = 1'b1;
        for (int i = 0; i < 100 && n_accept == a0; i++) begin
            @(posedge clk);
            #1;
        end
        ifc.req_valid = 1'b0;
        chk("t4_second_accept", n_accept - a0, 1);
        chk("t4_gap", gap, 1);
        wait_done(base_done + 2);
        chk("t4_beats", seen.size(), 8);
        for (int k = 0; k < 4 && 4 + k < seen.size(); k++) chk("t4_wdata2", seen[4 + k], 32'hB0 + k);

        // T5 reset after the second W beat
        base_done = n_done; base_beats = n_beats;
        issue(20'h55555, 8'h3C);
        for (int i = 0; i < 50 && n_beats < base_beats + 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_two_beats", n_beats - base_beats, 2);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_idle("t5_after_reset");
        chk("t5_no_done", n_done - base_done, 0);
        issue(20'h66666, 8'h3D);
        wait_done(base_done + 1);

        // T6 error response
        base_done = n_done; base_err = n_err;
        ifc.bresp = 2'b10;
        issue(20'h13579, 8'h3C);
        wait_done(base_done + 1);
        chk("t6_done_cnt", n_done - base_done, 1);
        chk("t6_err_cnt", n_err - base_err, 1);
        @(negedge clk);
        check_idle("t6_idle");
        ifc.bresp = 2'b00;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
